// File: rtl/ram2p_pkg.sv
// Shared constants for the dual-port RAM port initiator.
// Default geometry, op encoding and the FIFO count width helper.
package ram2p_pkg;

  localparam int AWID_D      = 8;
  localparam int DWID_D      = 16;
  localparam int RSP_DEPTH_D = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // count must represent DEPTH itself, hence the extra bit
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// First-word-fall-through response FIFO.
// Output holds the last popped word while empty.
module ram_rsp_fifo
  import ram2p_pkg::*;
#(
  parameter  int DWID  = DWID_D,
  parameter  int DEPTH = RSP_DEPTH_D,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [DWID-1:0] i_din,
  output logic [DWID-1:0] o_dout,
  output logic [CW-1:0]   o_count,
  output logic            o_empty
);

  logic [DWID-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic [DWID-1:0] r_last;
  logic            w_pop;

  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_cnt;
  assign o_dout  = o_empty ? r_last : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      unique case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Request-stream to RAM-port initiator with credit-based
// in-order read response buffering.
module ram_port_ctrl
  import ram2p_pkg::*;
#(
  parameter int AWID      = AWID_D,
  parameter int DWID      = DWID_D,
  parameter int RSP_DEPTH = RSP_DEPTH_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [AWID-1:0] i_req_addr,
  input  logic [DWID-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DWID-1:0] o_rsp_data,
  output logic            o_ram_we,
  output logic [AWID-1:0] o_ram_addr,
  output logic [DWID-1:0] o_ram_wdata,
  input  logic [DWID-1:0] i_ram_rdata,
  output logic            o_busy
);

  localparam int CW = cnt_w(RSP_DEPTH);

  logic            r_oor;
  logic            r_rd_p0;
  logic            r_rd_p1;
  logic            r_ram_we;
  logic [AWID-1:0] r_ram_addr;
  logic [DWID-1:0] r_ram_wdata;

  logic            w_acc;
  logic            w_pop;
  logic            w_empty;
  logic [CW-1:0]   w_cnt;
  logic [CW:0]     w_outst;

  // every in-flight read already owns a FIFO slot
  assign w_outst = {1'b0, w_cnt}
                 + (CW+1)'(r_rd_p0)
                 + (CW+1)'(r_rd_p1);

  assign o_req_ready = r_oor
                    && (w_outst < (CW+1)'(RSP_DEPTH));
  assign w_acc       = i_req_valid && o_req_ready;
  assign o_rsp_valid = !w_empty;
  assign w_pop       = o_rsp_valid && i_rsp_ready;
  assign o_busy      = (w_outst != '0);

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor       <= 1'b0;
      r_rd_p0     <= 1'b0;
      r_rd_p1     <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_oor    <= 1'b1;
      r_rd_p0  <= w_acc && (i_req_we == OP_RD);
      r_rd_p1  <= r_rd_p0;
      r_ram_we <= w_acc && (i_req_we == OP_WR);
      if (w_acc) begin
        r_ram_addr  <= i_req_addr;
        r_ram_wdata <= i_req_wdata;
      end
    end
  end

  ram_rsp_fifo #(
    .DWID  (DWID),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_p1),
    .i_pop   (w_pop),
    .i_din   (i_ram_rdata),
    .o_dout  (o_rsp_data),
    .o_count (w_cnt),
    .o_empty (w_empty)
  );

endmodule
